cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the multicycle main control FSM.
- Holds the architectural NZCV flags register and evaluates the instruction's 4-bit ARM condition field against those flags.
- Gates the FSM's raw write requests (RegW, MemW, NextPC, PCS) into the datapath's committed enables PCWrite, RegWrite, MemWrite and the flag write enables.
- The condition result is registered, so write-back cycles use the decision made in the preceding cycle.

Parameters:
- FLAGS_RST, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V} from the current cycle.
- FlagW  in  2  decoder flag-write request; [1] updates N,Z; [0] updates C,V.
- PCS  in  1  decoder: instruction writes PC (branch, or Rd==15 with RegW).
- NextPC  in  1  FSM: unconditional PC increment (fetch).
- RegW  in  1  FSM register-write request.
- MemW  in  1  FSM memory-write request.
- PCWrite  out  1  committed PC enable.
- RegWrite  out  1  committed register-file write enable.
- MemWrite  out  1  committed data-memory write enable.
- Flags  out  4  current NZCV register contents {N,Z,C,V}.
- CondEx  out  1  combinational condition result for the current Cond/Flags.

Behaviour:
- Flags register, 4 bits, async clear to FLAGS_RST when reset==0.
  - On each rising edge: if FlagWrite[1], Flags[3:2] <= ALUFlags[3:2]; if FlagWrite[0], Flags[1:0] <= ALUFlags[1:0].
  - The two halves update independently.
- FlagWrite[1:0] = FlagW & {2{CondEx}}. Flags update in the same cycle the condition is evaluated (EXECUTE), using the pre-update flags.
- CondEx, combinational from Cond and Flags (Flags, not ALUFlags):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never; reserved encoding is suppressed, never X)
- CondExReg, 1 bit, async clear to 0; captures CondEx on every rising edge (no enable).
- Committed enables, all combinational:
  - PCWrite = (PCS & CondExReg) | NextPC
  - RegWrite = RegW & CondExReg
  - MemWrite = MemW & CondExReg
- Latency:
  - Condition decision to write enable: exactly 1 cycle.
  - Flag update to visible Flags: 1 cycle.
  - Fetch PC increment (NextPC): 0 cycles, never gated.
- Timing relationship with the FSM sequence:
  - DECODE→BRANCH uses CondEx from DECODE.
  - EXECUTE→ALUWB uses CondEx from EXECUTE, evaluated before that instruction's own flag update.
  - MEMADR→MEMWRITE uses CondEx from MEMADR.
  - MEMREAD→MEMWB uses CondEx from MEMREAD. Memory instructions never set flags, so the flags are stable across this pair.
- Reset behaviour:
  - While reset==0: Flags=FLAGS_RST, CondExReg=0, RegWrite=0, MemWrite=0, PCWrite=NextPC. No flag writes occur.
  - Reset asserted mid-instruction aborts it: the first cycle after release cannot commit RegWrite/MemWrite/PCS.
- Simultaneous FlagW=2'b11 with a failing condition: no flag bits change.
- ALUFlags of X while FlagWrite==0 must not propagate into Flags.

Decomposition:
- Shared package holds:
  - Condition-code localparams COND_EQ..COND_NV (4'h0..4'hF).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: cond_check. Pure combinational Cond×Flags→CondEx decode, reusable by a future pipelined core.
- Flag and CondEx registers stay in cond_unit.

Test Plan:
- Reset: hold reset=0, NextPC=1, RegW=1 → Flags=4'b0000, RegWrite=0, PCWrite=1. Release → first-edge RegWrite=0.
- Flag set then EQ: Cond=1110, FlagW=11, ALUFlags=0100, one clock → Flags=0100. Then Cond=0000, RegW=1 on the next cycle → RegWrite=1 one cycle later. Same sequence with Cond=0001 → RegWrite=0.
- Partial write: Flags=1111, Cond=1110, FlagW=01, ALUFlags=0000 → Flags=1100.
- Failing condition suppresses flags: Flags=0000 (Z=0), Cond=0000, FlagW=11, ALUFlags=1111 → Flags stays 0000, FlagWrite=00.
- Signed compares: sweep all 16 Flags values × 16 Cond values against a reference model of CondEx. Explicitly check:
  - GT with N=1,V=1,Z=0 → 1
  - LE with Z=1 → 1
  - Cond=1111 → 0 for every Flags value
- Branch and store gating:
  - PCS=1, Cond=1011 (LT), N=1,V=0 held one cycle → PCWrite=1 next cycle.
  - With N=V → PCWrite=0.
  - MemW=1 under a failing condition → MemWrite=0.
  - NextPC=1 → PCWrite=1 regardless of Cond.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - condition codes and NZCV bit positions
package cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field decode against NZCV
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v, ge;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            // reserved encoding is forced low so it can never commit anything
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flags register and conditional gating of FSM write requests
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [1:0] flag_write;
    logic       cond_ex_reg;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (Flags),
        .cond_ex (CondEx)
    );

    assign flag_write = FlagW & {2{CondEx}};

    // N,Z and C,V halves are written independently; the decision uses pre-update flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= FLAGS_RST;
        end else begin
            if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cond_ex_reg <= 1'b0;
        else        cond_ex_reg <= CondEx;
    end

    // write-back cycles act on the decision registered in the preceding state
    assign PCWrite  = (PCS & cond_ex_reg) | NextPC;
    assign RegWrite = RegW & cond_ex_reg;
    assign MemWrite = MemW & cond_ex_reg;

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed self-checking bench for cond_unit
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW;
    logic       PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit #(.FLAGS_RST(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
        PCS = 0; RegW = 0; MemW = 0; NextPC = 0;
        tick();
        FlagW = 2'b00;
    endtask

    // reference decode: even code tests a base predicate, odd code inverts it
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = (c == 4'hE);
        endcase
        if (c[3:1] == 3'd7) return base;
        return c[0] ? !base : base;
    endfunction

    initial begin
        reset = 0; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111;
        PCS = 0; NextPC = 1; RegW = 1; MemW = 1;
        tick(); tick();
        check("rst_flags", Flags, 4'b0000);
        check("rst_regwrite", RegWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_pcwrite", PCWrite, 1);

        reset = 1; NextPC = 0; FlagW = 2'b00;
        #1;
        check("release_regwrite", RegWrite, 0);

        load_flags(4'b0100);
        check("flagset_eq", Flags, 4'b0100);
        Cond = 4'h0; RegW = 1;
        #1;
        check("eq_condex", CondEx, 1);
        tick();
        check("eq_regwrite", RegWrite, 1);
        Cond = 4'h1;
        tick();
        check("ne_regwrite", RegWrite, 0);

        load_flags(4'b1111);
        check("flags_all", Flags, 4'b1111);
        FlagW = 2'b01; ALUFlags = 4'b0000;
        tick();
        check("partial_cv", Flags, 4'b1100);
        FlagW = 2'b10; ALUFlags = 4'b0000;
        tick();
        check("partial_nz", Flags, 4'b0000);

        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        check("fail_no_flags", Flags, 4'b0000);
        Cond = 4'hE; FlagW = 2'b00; ALUFlags = 4'bxxxx;
        tick();
        check("x_alu_blocked", Flags, 4'b0000);

        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            check("sweep_load", Flags, 4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                check($sformatf("cond_%0d_flags_%0d", c, f), CondEx, ref_cond(4'(c), 4'(f)));
                if (c == 15) check("nv_never", CondEx, 0);
            end
        end

        load_flags(4'b1001);
        Cond = 4'hC; #1;
        check("gt_n1v1", CondEx, 1);
        load_flags(4'b0100);
        Cond = 4'hD; #1;
        check("le_z1", CondEx, 1);

        load_flags(4'b1000);
        Cond = 4'hB; PCS = 1;
        tick();
        check("lt_branch_taken", PCWrite, 1);
        PCS = 0;
        load_flags(4'b1001);
        Cond = 4'hB; PCS = 1;
        tick();
        check("lt_branch_not", PCWrite, 0);
        PCS = 0; MemW = 1;
        tick();
        check("store_gated", MemWrite, 0);
        Cond = 4'hF; NextPC = 1; MemW = 0;
        #1;
        check("nextpc_now", PCWrite, 1);
        tick();
        check("nextpc_after", PCWrite, 1);

        NextPC = 0; Cond = 4'hE; RegW = 1;
        tick();
        check("pre_abort_regwrite", RegWrite, 1);
        reset = 0;
        #1;
        check("abort_regwrite", RegWrite, 0);
        reset = 1;
        #1;
        check("abort_release", RegWrite, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
